// File: rtl/fpsqrt_pkg.sv
// Shared constants, state encoding and helpers for the FP square root unit.
// Format/rounding codes, per-format bias and iteration counts, canonical NaNs.
package fpsqrt_pkg;

    localparam logic [1:0] FMT_H = 2'd0;
    localparam logic [1:0] FMT_S = 2'd1;
    localparam logic [1:0] FMT_D = 2'd2;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FLAG_NV = 4;
    localparam int FLAG_NX = 0;

    localparam logic [10:0] BIAS_H = 11'd15;
    localparam logic [10:0] BIAS_S = 11'd127;
    localparam logic [10:0] BIAS_D = 11'd1023;

    localparam logic [3:0] ITERS_H = 4'd3;
    localparam logic [3:0] ITERS_S = 4'd7;
    localparam logic [3:0] ITERS_D = 4'd14;

    localparam logic [63:0] CNAN_H = 64'h0000_0000_0000_7E00;
    localparam logic [63:0] CNAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] CNAN_D = 64'h7FF8_0000_0000_0000;

    // root: 4 bits/iteration, up to 14 iterations
    localparam int ROOT_W = 56;
    // remainder: root width + growth headroom for the radix-4 shift
    localparam int REM_W  = 62;
    // radicand: two radicand bits per root bit
    localparam int RAD_W  = 112;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_POST
    } state_e;

    // leading zeros of a left-aligned 52-bit fraction
    function automatic logic [5:0] lzc52(input logic [51:0] f);
        logic [5:0] cnt;
        cnt = 6'd52;
        for (int i = 0; i < 52; i++) begin
            if (f[i]) cnt = 6'(51 - i);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fp_sqrt_r16_iter.sv
// One radix-16 square root iteration: two radix-4 digit steps on the
// partial root/remainder. Ports: root_i/rem_i in, next 8 radicand bits, root_o/rem_o out.
module fp_sqrt_r16_iter
    import fpsqrt_pkg::*;
#(
    parameter bit S0_CSA_SPECULATIVE = 1'b1,
    parameter bit S1_QDS_SPECULATIVE = 1'b1,
    parameter bit S1_CSA_SPECULATIVE = 1'b1
) (
    input  logic [ROOT_W-1:0] root_i,
    input  logic [REM_W-1:0]  rem_i,
    input  logic [7:0]        rad_i,
    output logic [ROOT_W-1:0] root_o,
    output logic [REM_W-1:0]  rem_o
);

    // All-digit form: candidates for d=1,2,3 compared in parallel.
    // (4q+d)^2 - 16q^2 = 8qd + d^2
    function automatic void r4_par(
        input  logic [ROOT_W-1:0] q,
        input  logic [REM_W-1:0]  r,
        input  logic [3:0]        b,
        output logic [ROOT_W-1:0] q_o,
        output logic [REM_W-1:0]  r_o
    );
        logic [REM_W-1:0] x;
        logic [REM_W-1:0] qq;
        logic [REM_W-1:0] t1;
        logic [REM_W-1:0] t2;
        logic [REM_W-1:0] t3;
        qq = REM_W'(q);
        x  = (r << 4) | REM_W'(b);
        t1 = (qq << 3) + REM_W'(1);
        t2 = (qq << 4) + REM_W'(4);
        t3 = t1 + t2 + REM_W'(4);
        if (x >= t3) begin
            q_o = (q << 2) | ROOT_W'(3);
            r_o = x - t3;
        end else if (x >= t2) begin
            q_o = (q << 2) | ROOT_W'(2);
            r_o = x - t2;
        end else if (x >= t1) begin
            q_o = (q << 2) | ROOT_W'(1);
            r_o = x - t1;
        end else begin
            q_o = q << 2;
            r_o = x;
        end
    endfunction

    // Serial form: the radix-4 digit as two restoring radix-2 bits.
    function automatic void r4_seq(
        input  logic [ROOT_W-1:0] q,
        input  logic [REM_W-1:0]  r,
        input  logic [3:0]        b,
        output logic [ROOT_W-1:0] q_o,
        output logic [REM_W-1:0]  r_o
    );
        logic [ROOT_W-1:0] qa;
        logic [REM_W-1:0]  ra;
        logic [REM_W-1:0]  x;
        logic [REM_W-1:0]  t;
        qa = q;
        ra = r;
        for (int k = 1; k >= 0; k--) begin
            x = (ra << 2) | REM_W'(k == 1 ? b[3:2] : b[1:0]);
            t = (REM_W'(qa) << 2) | REM_W'(1);
            if (x >= t) begin
                ra = x - t;
                qa = (qa << 1) | ROOT_W'(1);
            end else begin
                ra = x;
                qa = qa << 1;
            end
        end
        q_o = qa;
        r_o = ra;
    endfunction

    logic [ROOT_W-1:0] q_mid;
    logic [REM_W-1:0]  r_mid;
    logic [ROOT_W-1:0] q_end;
    logic [REM_W-1:0]  r_end;

    always_comb begin
        q_mid = '0;
        r_mid = '0;
        q_end = '0;
        r_end = '0;
        if (S0_CSA_SPECULATIVE) begin
            r4_par(root_i, rem_i, rad_i[7:4], q_mid, r_mid);
        end else begin
            r4_seq(root_i, rem_i, rad_i[7:4], q_mid, r_mid);
        end
        if (S1_QDS_SPECULATIVE || S1_CSA_SPECULATIVE) begin
            r4_par(q_mid, r_mid, rad_i[3:0], q_end, r_end);
        end else begin
            r4_seq(q_mid, r_mid, rad_i[3:0], q_end, r_end);
        end
        root_o = q_end;
        rem_o  = r_end;
    end

endmodule

// File: rtl/fp_sqrt_scalar_r16.sv
// Iterative radix-16 IEEE-754 square root for FP16/FP32/FP64 with RISC-V rounding and flags.
// Ports: start_valid_i/start_ready_o request, finish_valid_o/finish_ready_i result, flush_i abort.
module fp_sqrt_scalar_r16
    import fpsqrt_pkg::*;
#(
    parameter bit S0_CSA_SPECULATIVE = 1'b1,
    parameter bit S1_QDS_SPECULATIVE = 1'b1,
    parameter bit S1_CSA_SPECULATIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic        flush_i,
    input  logic [1:0]  fp_format_i,
    input  logic [63:0] op_i,
    input  logic [2:0]  rm_i,
    output logic        finish_valid_o,
    input  logic        finish_ready_i,
    output logic [63:0] fpsqrt_res_o,
    output logic [4:0]  fflags_o
);

    state_e             state_q, state_d;
    logic [63:0]        op_q, op_d;
    logic [1:0]         fmt_q, fmt_d;
    logic [2:0]         rm_q, rm_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [ROOT_W-1:0]  root_q, root_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [63:0]        res_q, res_d;
    logic [4:0]         flags_q, flags_d;
    logic               valid_q, valid_d;

    // operand decode, valid from PRE through POST since op_q is held
    logic               sign;
    logic [10:0]        exp_raw;
    logic [51:0]        frac;
    logic               exp_ones;
    logic [10:0]        bias;
    logic [3:0]         iters;
    logic [63:0]        op_m;
    logic [63:0]        cnan;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
    logic               spec;
    logic [63:0]        spec_res;
    logic [4:0]         spec_flags;
    logic [5:0]         lz;
    logic signed [12:0] e;
    logic signed [12:0] e_adj;
    logic signed [12:0] rexp;
    logic [10:0]        exp_res;
    logic [52:0]        sig;
    logic [RAD_W-1:0]   rad;

    always_comb begin
        sign     = op_q[63];
        exp_raw  = op_q[62:52];
        frac     = op_q[51:0];
        exp_ones = &op_q[62:52];
        bias     = BIAS_D;
        iters    = ITERS_D;
        op_m     = op_q;
        cnan     = CNAN_D;
        case (fmt_q)
            FMT_H: begin
                sign     = op_q[15];
                exp_raw  = {6'd0, op_q[14:10]};
                frac     = {op_q[9:0], 42'd0};
                exp_ones = &op_q[14:10];
                bias     = BIAS_H;
                iters    = ITERS_H;
                op_m     = {48'd0, op_q[15:0]};
                cnan     = CNAN_H;
            end
            FMT_S: begin
                sign     = op_q[31];
                exp_raw  = {3'd0, op_q[30:23]};
                frac     = {op_q[22:0], 29'd0};
                exp_ones = &op_q[30:23];
                bias     = BIAS_S;
                iters    = ITERS_S;
                op_m     = {32'd0, op_q[31:0]};
                cnan     = CNAN_S;
            end
            default: ;
        endcase

        is_nan  = exp_ones && (frac != '0);
        is_inf  = exp_ones && (frac == '0);
        is_zero = (exp_raw == '0) && (frac == '0);
        spec    = is_nan || is_inf || is_zero || sign;

        spec_flags = '0;
        spec_flags[FLAG_NV] = (is_nan && !frac[51]) ||
                              (sign && !is_zero && !is_nan);
        if (is_zero || (is_inf && !sign)) begin
            spec_res = op_m;
        end else begin
            spec_res = cnan;
        end

        // subnormal: shift the leading one out into the hidden position
        lz = lzc52(frac);
        if (exp_raw == '0) begin
            e   = -$signed({2'b00, bias}) - $signed({7'd0, lz});
            sig = {1'b1, frac << ({1'b0, lz} + 7'd1)};
        end else begin
            e   = $signed({2'b00, exp_raw}) - $signed({2'b00, bias});
            sig = {1'b1, frac};
        end

        // even exponent: odd ones fold a factor 2 into the mantissa
        e_adj   = e - $signed({12'd0, e[0]});
        rexp    = (e_adj >>> 1) + $signed({2'b00, bias});
        exp_res = rexp[10:0];
        if (e[0]) begin
            rad = {sig, 59'd0};
        end else begin
            rad = {1'b0, sig, 58'd0};
        end
    end

    logic [ROOT_W-1:0] root_nx;
    logic [REM_W-1:0]  rem_nx;

    fp_sqrt_r16_iter #(
        .S0_CSA_SPECULATIVE (S0_CSA_SPECULATIVE),
        .S1_QDS_SPECULATIVE (S1_QDS_SPECULATIVE),
        .S1_CSA_SPECULATIVE (S1_CSA_SPECULATIVE)
    ) u_iter (
        .root_i (root_q),
        .rem_i  (rem_q),
        .rad_i  (rad_q[RAD_W-1 -: 8]),
        .root_o (root_nx),
        .rem_o  (rem_nx)
    );

    // rounding: root left-aligned so the hidden bit sits at bit 55
    logic [ROOT_W-1:0] rootl;
    logic              g;
    logic              st;
    logic              lsb;
    logic              up;
    logic [63:0]       rnd_res;
    logic [4:0]        rnd_flags;

    always_comb begin
        rootl   = root_q;
        g       = root_q[2];
        st      = |root_q[1:0];
        lsb     = root_q[3];
        case (fmt_q)
            FMT_H: rootl = root_q << 44;
            FMT_S: rootl = root_q << 28;
            default: ;
        endcase
        case (fmt_q)
            FMT_H: begin
                lsb = rootl[45];
                g   = rootl[44];
                st  = |rootl[43:0];
            end
            FMT_S: begin
                lsb = rootl[32];
                g   = rootl[31];
                st  = |rootl[30:0];
            end
            default: ;
        endcase
        st = st || (rem_q != '0);

        case (rm_q)
            RM_RTZ, RM_RDN: up = 1'b0;
            RM_RUP:         up = g || st;
            RM_RMM:         up = g;
            default:        up = g && (st || lsb);
        endcase

        // carry out of the fraction ripples into the exponent field
        case (fmt_q)
            FMT_H: rnd_res = {48'd0,
                ({1'b0, exp_res[4:0], rootl[54:45]} + 16'(up))};
            FMT_S: rnd_res = {32'd0,
                ({1'b0, exp_res[7:0], rootl[54:32]} + 32'(up))};
            default: rnd_res =
                {1'b0, exp_res, rootl[54:3]} + 64'(up);
        endcase

        rnd_flags = '0;
        rnd_flags[FLAG_NX] = g || st;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fmt_d   = fmt_q;
        rm_d    = rm_q;
        rad_d   = rad_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_valid_i) begin
                        op_d    = op_i;
                        fmt_d   = fp_format_i;
                        rm_d    = rm_i;
                        state_d = ST_PRE;
                    end
                end
                ST_PRE: begin
                    rad_d   = rad;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = iters - 4'd1;
                    state_d = spec ? ST_POST : ST_ITER;
                end
                ST_ITER: begin
                    root_d = root_nx;
                    rem_d  = rem_nx;
                    rad_d  = rad_q << 8;
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == '0) state_d = ST_POST;
                end
                ST_POST: begin
                    // first POST cycle registers the packed result
                    if (!valid_q) begin
                        valid_d = 1'b1;
                        res_d   = spec ? spec_res : rnd_res;
                        flags_d = spec ? spec_flags : rnd_flags;
                    end else if (finish_ready_i) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            fmt_q   <= '0;
            rm_q    <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fmt_q   <= fmt_d;
            rm_q    <= rm_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign start_ready_o  = (state_q == ST_IDLE);
    assign finish_valid_o = valid_q;
    assign fpsqrt_res_o   = res_q;
    assign fflags_o       = flags_q;

endmodule

// File: tb/tb_fp_sqrt_scalar_r16.sv
// Directed bench for fp_sqrt_scalar_r16: scoreboard of expected results,
// latency, handshake hold, flush and mid-operation reset.
module tb_fp_sqrt_scalar_r16;

    logic        clk;
    logic        rst;
    logic        start_valid_i;
    logic        start_ready_o;
    logic        flush_i;
    logic [1:0]  fp_format_i;
    logic [63:0] op_i;
    logic [2:0]  rm_i;
    logic        finish_valid_o;
    logic        finish_ready_i;
    logic [63:0] fpsqrt_res_o;
    logic [4:0]  fflags_o;

    fp_sqrt_scalar_r16 dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .flush_i        (flush_i),
        .fp_format_i    (fp_format_i),
        .op_i           (op_i),
        .rm_i           (rm_i),
        .finish_valid_o (finish_valid_o),
        .finish_ready_i (finish_ready_i),
        .fpsqrt_res_o   (fpsqrt_res_o),
        .fflags_o       (fflags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  fl;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] f,
                         input logic [63:0] op, input logic [2:0] rm,
                         input logic [63:0] er, input logic [4:0] ef,
                         input int elat, input int hold);
        exp_t x;
        int   lat;
        sb.push_back({er, ef, 8'(elat)});
        @(negedge clk);
        start_valid_i  = 1'b1;
        fp_format_i    = f;
        op_i           = op;
        rm_i           = rm;
        finish_ready_i = 1'b0;
        @(posedge clk);
        #1;
        start_valid_i = 1'b0;
        lat = 0;
        while (!finish_valid_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        x = sb.pop_front();
        chk({tag, " lat"}, 128'(lat), 128'(x.lat));
        chk({tag, " res"}, 128'(fpsqrt_res_o), 128'(x.res));
        chk({tag, " flags"}, 128'(fflags_o), 128'(x.fl));
        for (int i = 0; i < hold; i++) begin
            // a new request while busy must be ignored
            start_valid_i = 1'b1;
            op_i          = 64'h4010_0000_0000_0000;
            @(posedge clk);
            #1;
            chk({tag, " hold"},
                128'({finish_valid_o, start_ready_o, fpsqrt_res_o, fflags_o}),
                128'({1'b1, 1'b0, x.res, x.fl}));
        end
        start_valid_i  = 1'b0;
        finish_ready_i = 1'b1;
        @(posedge clk);
        #1;
        finish_ready_i = 1'b0;
        chk({tag, " done"}, 128'({finish_valid_o, start_ready_o}),
            128'({1'b0, 1'b1}));
    endtask

    initial begin
        int   seen;
        int   e2;
        int   h;
        logic [7:0]  ex;
        logic [31:0] w;

        rst            = 1'b1;
        start_valid_i  = 1'b0;
        flush_i        = 1'b0;
        fp_format_i    = 2'd0;
        op_i           = '0;
        rm_i           = 3'd0;
        finish_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 128'({start_ready_o, finish_valid_o, fpsqrt_res_o,
            fflags_o}), 128'({1'b1, 1'b0, 64'd0, 5'd0}));
        @(negedge clk);
        rst = 1'b0;

        do_op("s_4", 2'd1, 64'h4080_0000, 3'd0, 64'h4000_0000, 5'h00, 9, 0);
        do_op("d_2_rne", 2'd2, 64'h4000_0000_0000_0000, 3'd0,
              64'h3FF6_A09E_667F_3BCD, 5'h01, 16, 0);
        do_op("d_2_rtz", 2'd2, 64'h4000_0000_0000_0000, 3'd1,
              64'h3FF6_A09E_667F_3BCC, 5'h01, 16, 0);
        do_op("d_2_rdn", 2'd2, 64'h4000_0000_0000_0000, 3'd2,
              64'h3FF6_A09E_667F_3BCC, 5'h01, 16, 0);
        do_op("d_2_rup", 2'd2, 64'h4000_0000_0000_0000, 3'd3,
              64'h3FF6_A09E_667F_3BCD, 5'h01, 16, 0);
        do_op("h_m1", 2'd0, 64'hBC00, 3'd0, 64'h7E00, 5'h10, 2, 0);
        do_op("s_m0", 2'd1, 64'h8000_0000, 3'd0, 64'h8000_0000, 5'h00, 2, 0);
        do_op("s_snan", 2'd1, 64'h7F80_0001, 3'd0, 64'h7FC0_0000, 5'h10, 2, 0);
        do_op("s_sub", 2'd1, 64'h0000_0001, 3'd0, 64'h1A35_04F3, 5'h01, 9, 0);
        do_op("s_inf", 2'd1, 64'h7F80_0000, 3'd0, 64'h7F80_0000, 5'h00, 2, 0);
        do_op("h_2_rne", 2'd0, 64'h4000, 3'd0, 64'h3DA8, 5'h01, 5, 0);
        do_op("h_2_rup", 2'd0, 64'h4000, 3'd3, 64'h3DA9, 5'h01, 5, 0);
        do_op("h_2_rmm", 2'd0, 64'h4000, 3'd4, 64'h3DA8, 5'h01, 5, 0);
        do_op("h_4", 2'd0, 64'h4400, 3'd0, 64'h4000, 5'h00, 5, 0);
        do_op("h_sub", 2'd0, 64'h0001, 3'd0, 64'h0C00, 5'h00, 5, 0);
        do_op("h_qnan", 2'd0, 64'h7E01, 3'd0, 64'h7E00, 5'h00, 2, 0);
        do_op("s_2_rup", 2'd1, 64'h4000_0000, 3'd3, 64'h3FB5_04F4, 5'h01, 9, 0);
        do_op("s_2_rm7", 2'd1, 64'h4000_0000, 3'd7, 64'h3FB5_04F3, 5'h01, 9, 0);
        do_op("s_upper", 2'd1, 64'hDEAD_BEEF_4110_0000, 3'd0,
              64'h4040_0000, 5'h00, 9, 0);
        do_op("d_minf", 2'd2, 64'hFFF0_0000_0000_0000, 3'd0,
              64'h7FF8_0000_0000_0000, 5'h10, 2, 0);
        do_op("d_m0", 2'd2, 64'h8000_0000_0000_0000, 3'd0,
              64'h8000_0000_0000_0000, 5'h00, 2, 0);
        do_op("f3_4", 2'd3, 64'h4010_0000_0000_0000, 3'd0,
              64'h4000_0000_0000_0000, 5'h00, 16, 0);
        do_op("s_hold", 2'd1, 64'h4080_0000, 3'd0, 64'h4000_0000, 5'h00, 9, 5);

        // exact FP64 squares under every rounding mode
        for (int n = 3; n < 11; n++) begin
            do_op("d_sq", 2'd2, $realtobits(real'(n * n)),
                  3'($urandom_range(0, 4)), $realtobits(real'(n)),
                  5'h00, 16, int'($urandom_range(0, 3)));
        end

        // FP32 powers of two: even exponents exact, odd ones give sqrt(2)
        for (int k = -3; k <= 3; k++) begin
            e2 = 3 * k;
            h  = (e2 - (e2 & 1)) / 2;
            ex = 8'(127 + e2);
            w  = {1'b0, 8'(127 + h), ((e2 & 1) != 0) ? 23'h3504F3 : 23'h0};
            do_op("s_pow2", 2'd1, {32'd0, 1'b0, ex, 23'd0}, 3'd0,
                  {32'd0, w}, ((e2 & 1) != 0) ? 5'h01 : 5'h00, 9, 0);
        end

        // flush in the middle of ITER
        @(negedge clk);
        start_valid_i = 1'b1;
        fp_format_i   = 2'd2;
        op_i          = 64'h4000_0000_0000_0000;
        rm_i          = 3'd0;
        @(posedge clk);
        #1;
        start_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_idle", 128'({start_ready_o, finish_valid_o}),
            128'({1'b1, 1'b0}));
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (finish_valid_o) seen++;
        end
        chk("flush_novalid", 128'(seen), 128'(0));

        do_op("post_flush", 2'd1, 64'h4080_0000, 3'd0,
              64'h4000_0000, 5'h00, 9, 0);

        // reset while iterating
        @(negedge clk);
        start_valid_i = 1'b1;
        fp_format_i   = 2'd2;
        op_i          = 64'h4000_0000_0000_0000;
        @(posedge clk);
        #1;
        start_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid", 128'({start_ready_o, finish_valid_o, fpsqrt_res_o,
            fflags_o}), 128'({1'b1, 1'b0, 64'd0, 5'd0}));
        @(negedge clk);
        rst = 1'b0;

        do_op("post_rst", 2'd0, 64'h4400, 3'd0, 64'h4000, 5'h00, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
